// File: rtl/regfile_wb_ctrl_if.sv
// Write-back controller bus: datapath request handshake, clear control,
// register-file write port and status. master = datapath side, slave = controller.
interface regfile_wb_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_index;
  logic [DATA_W-1:0]    in_data;
  logic                 clr_req;
  logic                 clr_busy;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_index;
  logic [DATA_W-1:0]    wr_data;
  logic [CNT_W-1:0]     fifo_count;
  logic [2**ADDR_W-1:0] pending;

  modport master (
    output in_valid, in_index, in_data, clr_req,
    input  in_ready, clr_busy, wr_en, wr_index, wr_data, fifo_count, pending
  );

  modport slave (
    input  in_valid, in_index, in_data, clr_req,
    output in_ready, clr_busy, wr_en, wr_index, wr_data, fifo_count, pending
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: buffers write requests in a small
// FIFO, issues one register write per cycle in order, and runs a sequenced
// clear of all registers after pending writes drain.
// Optional feature macro: WB_PENDING_EN builds per-register outstanding-write
// counters driving the pending mask; without it pending is tied to 0.
//
// state | meaning
// IDLE  | accept requests, issue queued writes
// DRAIN | clear requested; no new requests, issue remaining queued writes
// CLEAR | write zero to register clrIdx, one per cycle, 0..last
module regfile_wb_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] clrIdx;
  logic              wrEn;
  logic [ADDR_W-1:0] wrIndex;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] fifoIndex [DEPTH];
  logic [DATA_W-1:0] fifoData  [DEPTH];
  logic              inReady;
  logic              push;
  logic              pop;

  // Ready looks only at the registered count, so a full FIFO stays closed
  // even in a cycle that pops.
  assign inReady = !rst && (state == IDLE) && (count < CNT_W'(DEPTH));
  assign push    = bus.in_valid && inReady;
  assign pop     = ((state == IDLE) || (state == DRAIN)) && (count != '0);

  // FIFO storage write on accepted request
  always_ff @(posedge clk) begin
    if (push) begin
      fifoIndex[wrPtr] <= bus.in_index;
      fifoData[wrPtr]  <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencing FSM with registered write-port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clrIdx  <= '0;
      wrEn    <= 1'b0;
      wrIndex <= '0;
      wrData  <= '0;
    end else begin
      wrEn <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) state <= DRAIN;
        end
        DRAIN: begin
          // The first zero write is launched on the entry edge so that
          // every CLEAR cycle carries a write.
          if (count == '0) begin
            state   <= CLEAR;
            clrIdx  <= '0;
            wrEn    <= 1'b1;
            wrIndex <= '0;
            wrData  <= '0;
          end
        end
        CLEAR: begin
          if (clrIdx == '1) begin
            state  <= IDLE;
            clrIdx <= '0;
          end else begin
            clrIdx  <= clrIdx + 1'b1;
            wrEn    <= 1'b1;
            wrIndex <= clrIdx + 1'b1;
            wrData  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      // A pop never coincides with a clear write: pops need a non-empty
      // FIFO and CLEAR is only entered once it is empty.
      if (pop) begin
        wrEn    <= 1'b1;
        wrIndex <= fifoIndex[rdPtr];
        wrData  <= fifoData[rdPtr];
      end
    end
  end

`ifdef WB_PENDING_EN
  logic [CNT_W-1:0] pendCnt [NREG];
  logic [NREG-1:0]  incVec;
  logic [NREG-1:0]  decVec;
  logic [NREG-1:0]  pendMask;

  // One-hot increment/decrement strobes for the pushed and popped index
  always_comb begin
    incVec = '0;
    decVec = '0;
    if (push) incVec[bus.in_index] = 1'b1;
    if (pop)  decVec[fifoIndex[rdPtr]] = 1'b1;
  end

  // Per-register count of entries still queued
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pendCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({incVec[i], decVec[i]})
          2'b10:   pendCnt[i] <= pendCnt[i] + 1'b1;
          2'b01:   pendCnt[i] <= pendCnt[i] - 1'b1;
          default: pendCnt[i] <= pendCnt[i];
        endcase
      end
    end
  end

  // Non-zero count means a write to that register is outstanding
  always_comb begin
    for (int i = 0; i < NREG; i++) pendMask[i] = (pendCnt[i] != '0);
  end

  // Every register is about to be overwritten while a clear is in progress
  assign bus.pending = (state != IDLE) ? '1 : pendMask;
`else
  assign bus.pending = '0;
`endif

  assign bus.in_ready   = inReady;
  assign bus.clr_busy   = (state != IDLE);
  assign bus.wr_en      = wrEn;
  assign bus.wr_index   = wrIndex;
  assign bus.wr_data    = wrData;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_regfile_wb_ctrl;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  regfile_wb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: queue of accepted writes, controller mode
  // (0 idle, 1 draining, 2 clearing) and expected write-port values.
  ent_t              q[$];
  int                mode = 0;
  int                clrI = 0;
  logic              expEn = 1'b0;
  logic [ADDR_W-1:0] expIdx = '0;
  logic [DATA_W-1:0] expData = '0;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelReady();
    return (rst === 1'b0) && (mode == 0) && (q.size() < DEPTH);
  endfunction

  function automatic logic [7:0] modelPending();
    logic [7:0] m = '0;
`ifdef WB_PENDING_EN
    if (mode != 0) return 8'hFF;
    foreach (q[i]) m[q[i].idx] = 1'b1;
`endif
    return m;
  endfunction

  // One clock: sample inputs, advance the model across the edge, compare.
  task automatic tick();
    bit   acc;
    bit   cr;
    bit   r;
    int   sz;
    ent_t newE;
    ent_t e;
    acc  = (bus.in_valid === 1'b1) && modelReady();
    cr   = (bus.clr_req === 1'b1);
    r    = (rst === 1'b1);
    newE = '{idx: bus.in_index, data: bus.in_data};
    @(posedge clk);
    if (r) begin
      q.delete();
      mode    = 0;
      clrI    = 0;
      expEn   = 1'b0;
      expIdx  = '0;
      expData = '0;
    end else begin
      sz    = q.size();
      expEn = 1'b0;
      case (mode)
        0: begin
          if (sz > 0) begin
            e = q.pop_front();
            expEn = 1'b1; expIdx = e.idx; expData = e.data;
          end
          if (cr) mode = 1;
        end
        1: begin
          if (sz > 0) begin
            e = q.pop_front();
            expEn = 1'b1; expIdx = e.idx; expData = e.data;
          end else begin
            mode = 2; clrI = 0;
            expEn = 1'b1; expIdx = '0; expData = '0;
          end
        end
        default: begin
          if (clrI == 7) begin
            mode = 0; clrI = 0;
          end else begin
            clrI++;
            expEn = 1'b1; expIdx = ADDR_W'(clrI); expData = '0;
          end
        end
      endcase
      if (acc) q.push_back(newE);
    end
    #1;
    chk("wr_en", 64'(bus.wr_en), 64'(expEn));
    chk("wr_index", 64'(bus.wr_index), 64'(expIdx));
    chk("wr_data", 64'(bus.wr_data), 64'(expData));
    chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
    chk("clr_busy", 64'(bus.clr_busy), 64'(mode != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(modelReady()));
    chk("pending", 64'(bus.pending), 64'(modelPending()));
  endtask

  int seqIdx [10] = '{1, 2, 0, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_index = '0;
    bus.in_data  = '0;
    bus.clr_req  = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Single write: accepted at N, on wr_* in the cycle after N+1 only
    bus.in_valid = 1'b1; bus.in_index = 3'd3; bus.in_data = 32'hDEADBEEF;
    tick();
    chk("single_n_wr_en", 64'(bus.wr_en), 64'd0);
    chk("single_n_count", 64'(bus.fifo_count), 64'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("single_wr_en", 64'(bus.wr_en), 64'd1);
    chk("single_wr_index", 64'(bus.wr_index), 64'd3);
    chk("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    chk("single_count", 64'(bus.fifo_count), 64'd0);
    tick();
    chk("single_after_wr_en", 64'(bus.wr_en), 64'd0);
    chk("single_hold_index", 64'(bus.wr_index), 64'd3);

    // Five back-to-back requests, one pop per cycle keeps occupancy at 1
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_index = ADDR_W'(k + 1); bus.in_data = $urandom;
      tick();
      chk("stream_count", 64'(bus.fifo_count), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    tick();

    // Reset mid-burst
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_index = ADDR_W'(k); bus.in_data = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_count", 64'(bus.fifo_count), 64'd0);
    chk("midrst_wr_en", 64'(bus.wr_en), 64'd0);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Clear with queued writes
    bus.in_valid = 1'b1; bus.in_index = 3'd1; bus.in_data = 32'h11;
    tick();
    bus.in_index = 3'd2; bus.in_data = 32'h22; bus.clr_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.in_valid = 1'b0; bus.clr_req = 1'b0;
      chk("clr_seq_en", 64'(bus.wr_en), 64'd1);
      chk("clr_seq_index", 64'(bus.wr_index), 64'(seqIdx[k]));
      chk("clr_seq_data", 64'(bus.wr_data), (k == 0) ? 64'h11 : (k == 1) ? 64'h22 : 64'h0);
      chk("clr_seq_busy", 64'(bus.clr_busy), 64'd1);
      chk("clr_seq_ready", 64'(bus.in_ready), 64'd0);
`ifdef WB_PENDING_EN
      chk("clr_seq_pending", 64'(bus.pending), 64'hFF);
`else
      chk("clr_seq_pending", 64'(bus.pending), 64'h00);
`endif
    end
    tick();
    chk("clr_done_busy", 64'(bus.clr_busy), 64'd0);
    chk("clr_done_wr_en", 64'(bus.wr_en), 64'd0);

    // Reset while clearing at index 4
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.clr_busy === 1'b1 && bus.wr_en === 1'b1 && bus.wr_index === 3'd4) break;
      tick();
    end
    chk("clr_reach_idx4", 64'(bus.wr_index), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("clrrst_busy", 64'(bus.clr_busy), 64'd0);
    chk("clrrst_wr_en", 64'(bus.wr_en), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clrrst_no_zero_wr", 64'(bus.wr_en), 64'd0);
    end

    // Pending mask with two writes to register 5
    bus.in_valid = 1'b1; bus.in_index = 3'd5; bus.in_data = 32'h55;
    tick();
    bus.in_data = 32'h56;
    tick();
    bus.in_valid = 1'b0;
`ifdef WB_PENDING_EN
    chk("pend_second_queued", 64'(bus.pending), 64'h20);
`else
    chk("pend_second_queued", 64'(bus.pending), 64'h00);
`endif
    tick();
    chk("pend_second_issued", 64'(bus.pending), 64'h00);
    chk("pend_second_data", 64'(bus.wr_data), 64'h56);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_index = ADDR_W'($urandom);
      bus.in_data  = $urandom;
      bus.clr_req  = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
